// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: accumulates half-unit coin credit, vends one of
// NUM_PROD products at a common PRICE, tracks per-product stock and pays change or
// refunds as a contiguous train of half-unit pulses.
`timescale 1ns/1ps
module vending_machine_multi #(
  parameter int PRICE      = 4,
  parameter int MAX_CREDIT = 15,
  parameter int CREDIT_W   = 4,
  parameter int NUM_PROD   = 2,
  parameter int SEL_W      = 1,
  parameter int STOCK_INIT = 3,
  parameter int STOCK_W    = 2
) (
  input  logic                sys_clk,
  input  logic                sysRst,
  input  logic                piHalf,
  input  logic                piOne,
  input  logic [SEL_W-1:0]    piSel,
  input  logic                piCancel,
  input  logic                piRestock,
  output logic                OVend,
  output logic [SEL_W-1:0]    OProd,
  output logic                OChange,
  output logic                OReject,
  output logic [CREDIT_W-1:0] OCredit,
  output logic [NUM_PROD-1:0] OSoldOut,
  output logic                OBusy
);

  typedef enum logic [1:0] {IDLE, ACCUM, VEND, CHANGE} state_t;

  state_t              state, state_nxt;
  logic [CREDIT_W-1:0] credit, credit_nxt;
  logic [STOCK_W-1:0]  stock     [NUM_PROD];
  logic [STOCK_W-1:0]  stock_nxt [NUM_PROD];
  logic [SEL_W-1:0]    prod, prod_nxt;
  logic                reject, reject_nxt;

  logic [1:0]          coin_val;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_fits;
  logic                sel_ok;
  logic                can_vend;

  // Coin value is piHalf*1 + piOne*2, which is simply the two bits side by side.
  assign coin_val  = {piOne, piHalf};
  assign coin_sum  = {1'b0, credit} + {{(CREDIT_W-1){1'b0}}, coin_val};
  assign coin_fits = (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
  assign sel_ok    = (32'(piSel) < 32'(NUM_PROD));

  // Vend is possible when registered credit covers the price and the selection is in stock.
  always_comb begin
    can_vend = 1'b0;
    if (sel_ok && (credit >= CREDIT_W'(PRICE)))
      can_vend = (stock[piSel] != '0);
  end

  // Next-state, credit, stock and product-index decisions.
  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    prod_nxt   = prod;
    reject_nxt = 1'b0;
    for (int i = 0; i < NUM_PROD; i++) stock_nxt[i] = stock[i];

    case (state)
      IDLE, ACCUM: begin
        if (piRestock)
          for (int i = 0; i < NUM_PROD; i++) stock_nxt[i] = STOCK_W'(STOCK_INIT);
        if (coin_val != 2'b00) begin
          if (coin_fits) begin
            credit_nxt = coin_sum[CREDIT_W-1:0];
            if (state == IDLE) state_nxt = ACCUM;
          end else begin
            reject_nxt = 1'b1;
          end
        end
        // Cancel wins over a vend; an accepted coin in the same cycle joins the refund.
        if (state == ACCUM) begin
          if (piCancel) begin
            state_nxt = CHANGE;
          end else if (can_vend) begin
            state_nxt            = VEND;
            credit_nxt           = credit_nxt - CREDIT_W'(PRICE);
            stock_nxt[piSel]     = stock_nxt[piSel] - STOCK_W'(1);
            prod_nxt             = piSel;
          end
        end
      end
      VEND: begin
        reject_nxt = (coin_val != 2'b00);
        state_nxt  = (credit != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        reject_nxt = (coin_val != 2'b00);
        if (credit <= CREDIT_W'(1)) begin
          credit_nxt = '0;
          state_nxt  = IDLE;
        end else begin
          credit_nxt = credit - CREDIT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers; reset clears pending change immediately.
  always_ff @(posedge sys_clk or posedge sysRst) begin
    if (sysRst) begin
      state  <= IDLE;
      credit <= '0;
      prod   <= '0;
      reject <= 1'b0;
      for (int i = 0; i < NUM_PROD; i++) stock[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      state  <= state_nxt;
      credit <= credit_nxt;
      prod   <= prod_nxt;
      reject <= reject_nxt;
      for (int i = 0; i < NUM_PROD; i++) stock[i] <= stock_nxt[i];
    end
  end

  // Sold-out flags follow the registered stock counters.
  always_comb begin
    OSoldOut = '0;
    for (int i = 0; i < NUM_PROD; i++) OSoldOut[i] = (stock[i] == '0);
  end

  assign OVend   = (state == VEND);
  assign OChange = (state == CHANGE);
  assign OBusy   = (state == VEND) || (state == CHANGE);
  assign OReject = reject;
  assign OCredit = credit;
  assign OProd   = prod;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Bench for vending_machine_multi: directed scenarios followed by randomized purchase and
// refund transactions, checked against a transaction-level credit/stock model.
`timescale 1ns/1ps
module tb_vending_machine_multi;

  localparam int PRICE = 4, MAXC = 15, CW = 4, NP = 2, SW = 1, SI = 2, STW = 2;

  logic          sys_clk, sysRst;
  logic          piHalf, piOne, piCancel, piRestock;
  logic [SW-1:0] piSel;
  logic          OVend, OChange, OReject, OBusy;
  logic [SW-1:0] OProd;
  logic [CW-1:0] OCredit;
  logic [NP-1:0] OSoldOut;

  vending_machine_multi #(
    .PRICE(PRICE), .MAX_CREDIT(MAXC), .CREDIT_W(CW), .NUM_PROD(NP),
    .SEL_W(SW), .STOCK_INIT(SI), .STOCK_W(STW)
  ) dut (
    .sys_clk(sys_clk), .sysRst(sysRst), .piHalf(piHalf), .piOne(piOne),
    .piSel(piSel), .piCancel(piCancel), .piRestock(piRestock),
    .OVend(OVend), .OProd(OProd), .OChange(OChange), .OReject(OReject),
    .OCredit(OCredit), .OSoldOut(OSoldOut), .OBusy(OBusy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;

  // Reference model: credit in half-units and remaining stock per product.
  int m_credit;
  int m_stock [NP];

  function automatic logic [NP-1:0] m_soldout();
    logic [NP-1:0] s;
    for (int i = 0; i < NP; i++) s[i] = (m_stock[i] == 0);
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic model_reset();
    m_credit = 0;
    for (int i = 0; i < NP; i++) m_stock[i] = SI;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_vend"},    32'(OVend),    0);
    chk({tag, "_change"},  32'(OChange),  0);
    chk({tag, "_reject"},  32'(OReject),  0);
    chk({tag, "_busy"},    32'(OBusy),    0);
    chk({tag, "_prod"},    32'(OProd),    0);
    chk({tag, "_credit"},  32'(OCredit),  0);
    chk({tag, "_soldout"}, 32'(OSoldOut), 0);
  endtask

  // One coin cycle in IDLE/ACCUM that is not a vend-decision cycle.
  task automatic coin(input bit h, input bit o);
    int v;
    bit rej;
    v = int'(h) + 2 * int'(o);
    piHalf = h; piOne = o;
    tick();
    piHalf = 1'b0; piOne = 1'b0;
    rej = (m_credit + v > MAXC);
    if (!rej) m_credit += v;
    chk("coin_reject", 32'(OReject), 32'(rej));
    chk("coin_credit", 32'(OCredit), 32'(m_credit));
  endtask

  // Counts change pulses from the current sample until the machine is idle again.
  task automatic drain(input int n_exp, input int cnt0, input int vend_exp);
    int cnt, vends, k;
    cnt = cnt0; vends = 0; k = 0;
    while (OBusy && k < 64) begin
      if (OChange) cnt++;
      if (OVend) vends++;
      tick();
      k++;
    end
    chk("drain_done",    32'(OBusy),   0);
    chk("change_pulses", 32'(cnt),     32'(n_exp));
    chk("vend_count",    32'(vends),   32'(vend_exp));
    chk("final_credit",  32'(OCredit), 0);
    m_credit = 0;
  endtask

  // Decision cycle for a vend already funded: expect VEND then the change train.
  task automatic expect_vend(input int sel);
    tick();
    m_credit -= PRICE;
    m_stock[sel]--;
    chk("vend_strobe",  32'(OVend),    1);
    chk("vend_prod",    32'(OProd),    32'(sel));
    chk("vend_credit",  32'(OCredit),  32'(m_credit));
    chk("vend_soldout", 32'(OSoldOut), 32'(m_soldout()));
    drain(m_credit, 0, 1);
  endtask

  task automatic cancel();
    piCancel = 1'b1;
    tick();
    piCancel = 1'b0;
    chk("cancel_change", 32'(OChange), 32'(m_credit != 0));
    chk("cancel_credit", 32'(OCredit), 32'(m_credit));
    drain(m_credit, 0, 0);
  endtask

  task automatic restock();
    piRestock = 1'b1;
    tick();
    piRestock = 1'b0;
    for (int i = 0; i < NP; i++) m_stock[i] = SI;
    chk("restock_soldout", 32'(OSoldOut), 0);
  endtask

  initial begin
    int sel, cnt0, v;
    piHalf = 0; piOne = 0; piCancel = 0; piRestock = 0; piSel = '0;
    sysRst = 1'b1;
    model_reset();
    tick(); tick();
    chk_reset_outputs("reset");
    @(negedge sys_clk);
    sysRst = 1'b0;

    // 1: reset asserted in the middle of a refund train
    coin(0, 1);
    piCancel = 1'b1;
    tick();
    piCancel = 1'b0;
    chk("t1_in_change", 32'(OChange), 1);
    tick();
    chk("t1_credit_mid", 32'(OCredit), 1);
    #2 sysRst = 1'b1;
    #1;
    chk_reset_outputs("t1_midreset");
    model_reset();
    @(negedge sys_clk);
    sysRst = 1'b0;

    // 2: exact price, no change
    piSel = 1'b0;
    coin(0, 1);
    coin(0, 1);
    expect_vend(0);

    // 3: overpay by a half-unit
    piSel = 1'b1;
    coin(1, 0);
    coin(0, 1);
    coin(0, 1);
    expect_vend(1);

    // 4: both coins at once then refund
    coin(1, 1);
    cancel();

    // 5: sold-out product holds credit; overflow rejected; switch to an in-stock product
    coin(0, 1);
    coin(0, 1);
    expect_vend(1);
    chk("t5_soldout", 32'(OSoldOut), 32'(2'b10));
    coin(0, 1);
    coin(0, 1);
    tick(); tick();
    chk("t5_no_vend",   32'(OVend),   0);
    chk("t5_held",      32'(OCredit), 4);
    for (int i = 0; i < 5; i++) coin(0, 1);
    coin(1, 0);
    chk("t5_full", 32'(OCredit), 15);
    coin(0, 1);
    piSel = 1'b0;
    expect_vend(0);

    // 6: coin and cancel during the change train are ignored, then restock
    coin(1, 1);
    piCancel = 1'b1;
    tick();
    piCancel = 1'b0;
    cnt0 = OChange ? 1 : 0;
    piOne = 1'b1; piCancel = 1'b1;
    tick();
    piOne = 1'b0; piCancel = 1'b0;
    chk("t6_reject", 32'(OReject), 1);
    chk("t6_credit", 32'(OCredit), 2);
    drain(3, cnt0, 0);
    restock();

    // Randomized purchases and refunds
    for (int t = 0; t < 40; t++) begin
      sel = int'($urandom_range(0, NP - 1));
      if (m_stock[sel] == 0) restock();
      piSel = SW'(sel);
      while (m_credit < PRICE) begin
        v = int'($urandom_range(1, 3));
        coin(v[0], v[1]);
        if (m_credit < PRICE && $urandom_range(0, 7) == 0) cancel();
      end
      expect_vend(sel);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
